reg_file_param: RTL and testbench

Parametrised successor of the processor register file: synchronous write, registered dual read, plus a priority test-write port, two selectable debug taps, optional hardwired-zero register 0, and optional write-to-read bypass. A built-in clear sequencer zeroes the whole array after reset or on request, so the array needs no reset fan-out. Sits in the datapath between decode (SR1/SR2/DR) and writeback (Reg_In). The debug taps drive board LEDs and the test harness.

---
 rtl/reg_file_param.sv | 154 +++++++++++++++
 tb/tb_reg_file_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised processor register file with a test-write port, debug taps and a
// self-clearing array that is zeroed by a sequencer instead of a reset tree.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegW,
  input  logic [ADDR_W-1:0] DR,
  input  logic [DATA_W-1:0] Reg_In,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  output logic [DATA_W-1:0] ReadReg1,
  output logic [DATA_W-1:0] ReadReg2,
  input  logic              TestW,
  input  logic [ADDR_W-1:0] TestAddr,
  input  logic [DATA_W-1:0] TestData,
  input  logic              Clear,
  output logic              Busy,
  output logic              WrDrop,
  input  logic [ADDR_W-1:0] DbgSel0,
  input  logic [ADDR_W-1:0] DbgSel1,
  output logic [DATA_W-1:0] DbgOut0,
  output logic [DATA_W-1:0] DbgOut1,
  output logic              o_dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic              r_wrdrop;
  logic              w_busy;
  logic              w_reg_we;
  logic              w_test_we;
  logic [DATA_W-1:0] w_rd1_nxt;
  logic [DATA_W-1:0] w_rd2_nxt;

  // Write qualification: nothing commits while clearing, and address 0 is
  // silently ignored (no drop pulse) when it is hardwired to zero.
  always_comb begin
    w_busy    = (r_state == ST_CLEAR);
    w_reg_we  = !w_busy && RegW  && !((ZERO_REG != 0) && (DR == '0));
    w_test_we = !w_busy && TestW && !((ZERO_REG != 0) && (TestAddr == '0));
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_CLEAR: begin
        w_idx_nxt = r_idx + IDX_ONE;
        if (r_idx == IDX_LAST) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (Clear) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_CLEAR;
      r_idx    <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_wrdrop <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rd1    <= w_rd1_nxt;
      r_rd2    <= w_rd2_nxt;
      r_wrdrop <= w_busy && (RegW || TestW);
    end
  end

  // The array has no reset; an edge during reset only rewrites entry 0 with
  // zero, which the restarted clear sequence repeats anyway. The test port
  // is assigned last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (w_busy) begin
      r_mem[r_idx] <= '0;
    end else begin
      if (w_reg_we) begin
        r_mem[DR] <= Reg_In;
      end
      if (w_test_we) begin
        r_mem[TestAddr] <= TestData;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = r_mem[addr];
    if (w_busy || ((ZERO_REG != 0) && (addr == '0))) begin
      val = '0;
    end else if ((BYPASS != 0) && w_test_we && (TestAddr == addr)) begin
      val = TestData;
    end else if ((BYPASS != 0) && w_reg_we && (DR == addr)) begin
      val = Reg_In;
    end
    return val;
  endfunction

  function automatic logic [DATA_W-1:0] tap(input logic [ADDR_W-1:0] sel);
    logic [DATA_W-1:0] val;
    val = r_mem[sel];
    if (w_busy || ((ZERO_REG != 0) && (sel == '0))) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    w_rd1_nxt = read_port(SR1);
    w_rd2_nxt = read_port(SR2);
  end

  always_comb begin
    ReadReg1    = r_rd1;
    ReadReg2    = r_rd2;
    Busy        = w_busy;
    WrDrop      = r_wrdrop;
    DbgOut0     = tap(DbgSel0);
    DbgOut1     = tap(DbgSel1);
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: clear sequencing, write/read latency,
// bypass, write priority, hardwired zero, drop pulses and async reset abort.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reg_w = 1'b0;
  logic [4:0]  dr = '0;
  logic [31:0] reg_in = '0;
  logic [4:0]  sr1 = '0;
  logic [4:0]  sr2 = '0;
  logic [31:0] read_reg1;
  logic [31:0] read_reg2;
  logic        test_w = 1'b0;
  logic [4:0]  test_addr = '0;
  logic [31:0] test_data = '0;
  logic        clear = 1'b0;
  logic        busy;
  logic        wr_drop;
  logic [4:0]  dbg_sel0 = '0;
  logic [4:0]  dbg_sel1 = '0;
  logic [31:0] dbg_out0;
  logic [31:0] dbg_out1;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edges;

  reg_file_param dut (
    .CLK(clk), .RST_N(rst_n), .RegW(reg_w), .DR(dr), .Reg_In(reg_in),
    .SR1(sr1), .SR2(sr2), .ReadReg1(read_reg1), .ReadReg2(read_reg2),
    .TestW(test_w), .TestAddr(test_addr), .TestData(test_data),
    .Clear(clear), .Busy(busy), .WrDrop(wr_drop),
    .DbgSel0(dbg_sel0), .DbgSel1(dbg_sel1), .DbgOut0(dbg_out0), .DbgOut1(dbg_out1),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and outputs are touched 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic idle_inputs();
    reg_w = 1'b0; test_w = 1'b0; clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_wrdrop", wr_drop, 0);
    check_eq("rst_rd1", read_reg1, 0);
    check_eq("rst_rd2", read_reg2, 0);
    check_eq("rst_dbg0", dbg_out0, 0);
    step();
    step();
    rst_n = 1'b1;

    // Initial clear: 32 edges of Busy
    count_busy(n_edges);
    check_eq("init_clear_len", n_edges, 32);
    check_eq("init_state_ready", dbg_state, 1);
    dbg_sel0 = 5'd7;
    #1 check_eq("init_dbg7", dbg_out0, 0);

    // Plain write then read
    reg_w = 1'b1; dr = 5'd3; reg_in = 32'hDEADBEEF;
    step();
    reg_w = 1'b0; dbg_sel1 = 5'd3; sr1 = 5'd3;
    #1 check_eq("wr_dbg1_same_cycle", dbg_out1, 32'hDEADBEEF);
    step();
    check_eq("rd1_after_write", read_reg1, 32'hDEADBEEF);

    // Same-cycle write/read bypass on port 2
    reg_w = 1'b1; dr = 5'd5; reg_in = 32'h12345678; sr2 = 5'd5;
    step();
    reg_w = 1'b0;
    check_eq("bypass_rd2", read_reg2, 32'h12345678);
    check_eq("bypass_rd1_other", read_reg1, 32'hDEADBEEF);

    // Test port alone, bypassed to port 2
    test_w = 1'b1; test_addr = 5'd9; test_data = 32'hCAFE0009; sr2 = 5'd9;
    step();
    test_w = 1'b0;
    check_eq("test_bypass_rd2", read_reg2, 32'hCAFE0009);

    // Collision: test port wins both the array and the bypass
    reg_w = 1'b1; dr = 5'd1; reg_in = 32'h0000AAAA;
    test_w = 1'b1; test_addr = 5'd1; test_data = 32'h00000055; sr1 = 5'd1;
    step();
    idle_inputs();
    check_eq("prio_bypass_rd1", read_reg1, 32'h00000055);
    dbg_sel0 = 5'd1;
    #1 check_eq("prio_array", dbg_out0, 32'h00000055);

    // Hardwired zero register: ignored, no drop
    reg_w = 1'b1; dr = 5'd0; reg_in = 32'h0000FFFF; sr1 = 5'd0;
    step();
    reg_w = 1'b0;
    check_eq("zero_rd1", read_reg1, 0);
    check_eq("zero_no_drop_a", wr_drop, 0);
    dbg_sel0 = 5'd0;
    step();
    check_eq("zero_no_drop_b", wr_drop, 0);
    check_eq("zero_dbg0", dbg_out0, 0);

    // Clear request with a same-cycle write that still commits
    clear = 1'b1; reg_w = 1'b1; dr = 5'd6; reg_in = 32'h00000066; sr1 = 5'd3;
    step();
    idle_inputs();
    check_eq("clr_busy", busy, 1);
    check_eq("clr_state", dbg_state, 0);
    dbg_sel0 = 5'd6;
    #1 check_eq("clr_dbg_forced", dbg_out0, 0);
    step();
    check_eq("clr_rd1_zero", read_reg1, 0);
    reg_w = 1'b1; dr = 5'd4; reg_in = 32'h00000099; clear = 1'b1;
    step();
    idle_inputs();
    check_eq("clr_drop_pulse", wr_drop, 1);
    step();
    check_eq("clr_drop_end", wr_drop, 0);
    count_busy(n_edges);
    check_eq("clr_len", n_edges + 3, 32);
    dbg_sel0 = 5'd4; dbg_sel1 = 5'd6;
    #1;
    check_eq("clr_reg4", dbg_out0, 0);
    check_eq("clr_reg6", dbg_out1, 0);
    dbg_sel0 = 5'd3;
    #1 check_eq("clr_reg3", dbg_out0, 0);

    // Reset in the middle of a clear sequence (idx = 10)
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    reg_w = 1'b1; dr = 5'd8;
    step();
    reg_w = 1'b0;
    check_eq("mid_drop", wr_drop, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1);
    check_eq("mid_rst_drop", wr_drop, 0);
    check_eq("mid_rst_rd1", read_reg1, 0);
    check_eq("mid_rst_rd2", read_reg2, 0);
    step();
    rst_n = 1'b1;
    count_busy(n_edges);
    check_eq("mid_restart_len", n_edges, 32);

    // Reset while READY discards a held read value immediately
    reg_w = 1'b1; dr = 5'd2; reg_in = 32'h00001234; sr1 = 5'd2;
    step();
    reg_w = 1'b0;
    check_eq("ready_rd1", read_reg1, 32'h00001234);
    dbg_sel0 = 5'd2;
    #2 rst_n = 1'b0;
    #1;
    check_eq("ready_rst_rd1", read_reg1, 0);
    check_eq("ready_rst_dbg0", dbg_out0, 0);
    step();
    rst_n = 1'b1;
    count_busy(n_edges);
    check_eq("final_clear_len", n_edges, 32);
    #1 check_eq("final_reg2", dbg_out0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
